// File: rtl/hit_event_fifo_if.sv
// SPI link between the hit event FIFO (slave) and the readout MCU (master).
// Mode 0 (CPOL=0, CPHA=0), chip select active-low, MSB first.
interface hit_event_fifo_if;
    logic spi_cs;
    logic spi_clk;
    logic spi_miso;

    modport master (output spi_cs, output spi_clk, input spi_miso);
    modport slave  (input spi_cs, input spi_clk, output spi_miso);
endinterface

// File: rtl/hit_event_fifo.sv
// hit_event_fifo: latches CHANNELS asynchronous hit lines over a coincidence
// window, commits each window as one event into a DEPTH-entry FIFO and serves
// the head entry to an MCU over a mode-0 SPI slave.
// Optional feature macro: HIT_TIMESTAMP_EN adds a free-running timestamp and
// a TS_WIDTH timestamp field per event (appended after Q in the SPI frame).
module hit_event_fifo #(
    parameter int CHANNELS = 24,
    parameter int DEPTH    = 8,
    parameter int WINDOW   = 64,
    parameter int TS_WIDTH = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    S,
    hit_event_fifo_if.slave        spi,
    output logic                   trigger,
    output logic                   trigger_led,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef HIT_TIMESTAMP_EN
    localparam int TS_FIELD_W = TS_WIDTH;
`else
    // No timestamp field in this build; the width collapses to zero.
    localparam int TS_FIELD_W = 0 * TS_WIDTH;
`endif
    localparam int ENTRY_W = CHANNELS + TS_FIELD_W;
    localparam int FRAME_W = 8 + ENTRY_W;
    localparam int BCW     = $clog2(FRAME_W + 1);

    localparam logic [15:0]    WIN_LOAD  = 16'(WINDOW - 1);
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);
    localparam logic [BCW-1:0] FRAME_LEN = BCW'(FRAME_W);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // synchronizer stages and previous values
    logic [CHANNELS-1:0] s_sync1_r, s_sync2_r;
    logic cs_sync1_r, cs_sync2_r, cs_prev_r;
    logic clk_sync1_r, clk_sync2_r, clk_prev_r;

    // capture FSM
    state_t              state_r;
    logic [CHANNELS-1:0] q_r;
    logic [15:0]         win_cnt_r;
    logic                trigger_r;

    // FIFO
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]      count_r, count_nxt_s;
    logic               overflow_r, trigger_led_r;

    // SPI
    logic [FRAME_W-1:0] sr_r, frame_s;
    logic [BCW-1:0]     bit_cnt_r;
    logic               miso_r, hdr_valid_r, hdr_ov_r;

    logic hit_any_s, cs_fall_s, cs_rise_s, clk_rise_s, clk_fall_s;
    logic push_s, drop_s, pop_s, valid_s;
    logic [ENTRY_W-1:0] entry_in_s, head_s;
    logic [5:0]         count_sat_s;

    assign hit_any_s  = |s_sync2_r;
    assign cs_fall_s  = cs_prev_r & ~cs_sync2_r;
    assign cs_rise_s  = ~cs_prev_r & cs_sync2_r;
    // SPI clock edges only count while the slave is selected
    assign clk_rise_s = ~clk_prev_r & clk_sync2_r & ~cs_sync2_r;
    assign clk_fall_s = clk_prev_r & ~clk_sync2_r & ~cs_sync2_r;

    assign valid_s = (count_r != {CW{1'b0}});
    assign push_s  = (state_r == ST_COMMIT) && (count_r != CNT_FULL);
    assign drop_s  = (state_r == ST_COMMIT) && (count_r == CNT_FULL);
    // hdr_valid_r guarantees a pop never hits an empty FIFO
    assign pop_s   = cs_rise_s && (bit_cnt_r == FRAME_LEN) && hdr_valid_r;

    assign trigger     = trigger_r;
    assign trigger_led = trigger_led_r;
    assign fifo_count  = count_r;
    assign overflow    = overflow_r;
    assign spi.spi_miso = miso_r;

    // Two-flop synchronizers for hit lines and the SPI pins, plus previous values for edge detect
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            s_sync1_r   <= '0;
            s_sync2_r   <= '0;
            cs_sync1_r  <= 1'b1;
            cs_sync2_r  <= 1'b1;
            cs_prev_r   <= 1'b1;
            clk_sync1_r <= 1'b0;
            clk_sync2_r <= 1'b0;
            clk_prev_r  <= 1'b0;
        end else begin
            s_sync1_r   <= S;
            s_sync2_r   <= s_sync1_r;
            cs_sync1_r  <= spi.spi_cs;
            cs_sync2_r  <= cs_sync1_r;
            cs_prev_r   <= cs_sync2_r;
            clk_sync1_r <= spi.spi_clk;
            clk_sync2_r <= clk_sync1_r;
            clk_prev_r  <= clk_sync2_r;
        end
    end

    // Coincidence capture FSM; COMMIT re-arms immediately so no hit is lost across it
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            q_r       <= '0;
            win_cnt_r <= 16'd0;
            trigger_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_any_s) begin
                        q_r       <= s_sync2_r;
                        win_cnt_r <= WIN_LOAD;
                        state_r   <= ST_WINDOW;
                        trigger_r <= 1'b1;
                    end else begin
                        trigger_r <= 1'b0;
                    end
                end
                ST_WINDOW: begin
                    q_r       <= q_r | s_sync2_r;
                    trigger_r <= 1'b1;
                    if (win_cnt_r == 16'd0) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        win_cnt_r <= win_cnt_r - 16'd1;
                    end
                end
                ST_COMMIT: begin
                    q_r <= s_sync2_r;
                    if (hit_any_s) begin
                        win_cnt_r <= WIN_LOAD;
                        state_r   <= ST_WINDOW;
                        trigger_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        trigger_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    q_r       <= '0;
                    trigger_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_r, ts_cap_r;

    // Free-running timestamp, sampled whenever a new window opens
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ts_r     <= '0;
            ts_cap_r <= '0;
        end else begin
            ts_r <= ts_r + TS_WIDTH'(1);
            if (((state_r == ST_IDLE) || (state_r == ST_COMMIT)) && hit_any_s) begin
                ts_cap_r <= ts_r;
            end
        end
    end

    assign entry_in_s = {ts_cap_r, q_r};
`else
    assign entry_in_s = q_r;
`endif

    // FIFO storage array (no reset needed: only entries below count_r are ever read out)
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_in_s;
        end
    end

    // Next occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy, sticky overflow (a drop beats a clear) and status LED
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            overflow_r    <= 1'b0;
            trigger_led_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r       <= count_nxt_s;
            trigger_led_r <= (count_nxt_s != {CW{1'b0}});
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (pop_s && hdr_ov_r) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Frame assembly: header {valid, overflow, count sat 63}, Q, then timestamp
    always_comb begin
        head_s      = valid_s ? mem_r[rd_ptr_r] : {ENTRY_W{1'b0}};
        count_sat_s = (7'(count_r) > 7'd63) ? 6'd63 : 6'(count_r);
`ifdef HIT_TIMESTAMP_EN
        frame_s = {valid_s, overflow_r, count_sat_s,
                   head_s[CHANNELS-1:0], head_s[ENTRY_W-1:CHANNELS]};
`else
        frame_s = {valid_s, overflow_r, count_sat_s, head_s};
`endif
    end

    // SPI slave shifter: load on CS fall, count on SCK rise, shift out on SCK fall
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sr_r        <= '0;
            bit_cnt_r   <= '0;
            miso_r      <= 1'b0;
            hdr_valid_r <= 1'b0;
            hdr_ov_r    <= 1'b0;
        end else if (cs_fall_s) begin
            sr_r        <= frame_s;
            bit_cnt_r   <= '0;
            miso_r      <= frame_s[FRAME_W-1];
            hdr_valid_r <= frame_s[FRAME_W-1];
            hdr_ov_r    <= frame_s[FRAME_W-2];
        end else if (cs_rise_s) begin
            miso_r      <= 1'b0;
            hdr_valid_r <= 1'b0;
        end else if (clk_rise_s) begin
            if (bit_cnt_r != FRAME_LEN) begin
                bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
        end else if (clk_fall_s) begin
            if (bit_cnt_r < FRAME_LEN) begin
                sr_r   <= sr_r << 1;
                miso_r <= sr_r[FRAME_W-2];
            end else begin
                miso_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hit_event_fifo.sv
// Directed self-checking bench for hit_event_fifo (WINDOW=4, DEPTH=8, 24 channels).
// Define HIT_TIMESTAMP_EN on both RTL and bench to include the timestamp case.
module tb_hit_event_fifo;
    localparam int CH  = 24;
    localparam int DEP = 8;
    localparam int WIN = 4;
`ifdef HIT_TIMESTAMP_EN
    localparam int TSW = 4;
    localparam int F   = 8 + CH + TSW;
`else
    localparam int TSW = 16;
    localparam int F   = 8 + CH;
`endif

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] S;
    logic          trigger;
    logic          trigger_led;
    logic [3:0]    fifo_count;
    logic          overflow;
    logic [F-1:0]  rd_frame;
    int            checks = 0;
    int            errors = 0;

    hit_event_fifo_if spi_bus ();

    hit_event_fifo #(
        .CHANNELS(CH), .DEPTH(DEP), .WINDOW(WIN), .TS_WIDTH(TSW)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .S          (S),
        .spi        (spi_bus),
        .trigger    (trigger),
        .trigger_led(trigger_led),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse(input logic [CH-1:0] v);
        S = v;
        cyc(1);
        S = '0;
    endtask

    // Clock out nbits of a frame; levels held 6 sys_clk cycles each
    task automatic spi_read(input int nbits);
        rd_frame = '0;
        spi_bus.spi_cs = 1'b0;
        cyc(6);
        for (int i = 0; i < nbits; i++) begin
            rd_frame = {rd_frame[F-2:0], spi_bus.spi_miso};
            spi_bus.spi_clk = 1'b1;
            cyc(6);
            spi_bus.spi_clk = 1'b0;
            cyc(6);
        end
        if (nbits == F) check_eq("miso_zero_after_frame", 64'(spi_bus.spi_miso), 64'd0);
        spi_bus.spi_cs = 1'b1;
        cyc(6);
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp_hdr, input logic [CH-1:0] exp_q);
        spi_read(F);
        check_eq({tag, "_hdr"}, 64'(rd_frame[F-1 -: 8]), 64'(exp_hdr));
        check_eq({tag, "_q"}, 64'(rd_frame[F-9 -: CH]), 64'(exp_q));
    endtask

    initial begin
        int hi_cnt;
        int first_hi;
        int rises;
        logic prev_trig;
        logic [3:0] cnt_c6;
        logic [3:0] cnt_c7;
`ifdef HIT_TIMESTAMP_EN
        logic [TSW-1:0] ts_a;
        logic [TSW-1:0] ts_b;
        logic [TSW-1:0] ts_d;
`endif
        rst_n = 1'b0;
        S = '0;
        spi_bus.spi_cs = 1'b1;
        spi_bus.spi_clk = 1'b0;
        cyc(3);
        check_eq("rst_trigger", 64'(trigger), 64'd0);
        check_eq("rst_led", 64'(trigger_led), 64'd0);
        check_eq("rst_count", 64'(fifo_count), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_miso", 64'(spi_bus.spi_miso), 64'd0);
        rst_n = 1'b1;
        cyc(2);

        // single 3-cycle hit: trigger for WINDOW+1 cycles, push 7 edges after S sampled
        hi_cnt = 0; first_hi = -1; cnt_c6 = 4'hF; cnt_c7 = 4'hF;
        S = 24'h000001;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) S = '0;
            @(negedge sys_clk);
            if (trigger) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
            end
            if (c == 6) cnt_c6 = fifo_count;
            if (c == 7) cnt_c7 = fifo_count;
        end
        check_eq("single_trig_len", 64'(hi_cnt), 64'd5);
        check_eq("single_trig_start", 64'(first_hi), 64'd2);
        check_eq("single_count_before", 64'(cnt_c6), 64'd0);
        check_eq("single_count_after", 64'(cnt_c7), 64'd1);
        check_eq("single_led", 64'(trigger_led), 64'd1);
        read_check("single", 8'h81, 24'h000001);
        check_eq("single_drained", 64'(fifo_count), 64'd0);
        check_eq("single_led_off", 64'(trigger_led), 64'd0);

        // two hits 2 cycles apart merge into one event
        pulse(24'h000010);
        cyc(1);
        pulse(24'h800000);
        cyc(15);
        check_eq("merge_count", 64'(fifo_count), 64'd1);
        read_check("merge", 8'h81, 24'h800010);

        // second hit in the last WINDOW cycle still merges
        pulse(24'h000004);
        cyc(3);
        pulse(24'h000008);
        cyc(15);
        check_eq("lastwin_count", 64'(fifo_count), 64'd1);
        read_check("lastwin", 8'h81, 24'h00000C);

        // second hit lands in COMMIT: two events, trigger continuous
        hi_cnt = 0; rises = 0; prev_trig = 1'b0;
        S = 24'h000001;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) S = '0;
            if (c == WIN + 1) S = 24'h000002;
            if (c == WIN + 2) S = '0;
            @(negedge sys_clk);
            if (trigger) hi_cnt++;
            if (trigger && !prev_trig) rises++;
            prev_trig = trigger;
        end
        check_eq("commit_trig_len", 64'(hi_cnt), 64'd10);
        check_eq("commit_trig_rises", 64'(rises), 64'd1);
        check_eq("commit_count", 64'(fifo_count), 64'd2);
        read_check("commit_ev1", 8'h82, 24'h000001);
        read_check("commit_ev2", 8'h81, 24'h000002);

        // fill 8 then a 9th event is dropped
        for (int i = 0; i < 9; i++) begin
            pulse(CH'(i + 1));
            cyc(11);
        end
        check_eq("full_count", 64'(fifo_count), 64'd8);
        check_eq("full_overflow", 64'(overflow), 64'd1);
        read_check("full_rd", 8'hC8, 24'h000001);
        check_eq("ovf_cleared", 64'(overflow), 64'd0);
        check_eq("after_full_count", 64'(fifo_count), 64'd7);
        read_check("rd2", 8'h87, 24'h000002);

        // aborted read after 10 bits: no pop, retry returns the same event
        spi_read(10);
        check_eq("partial_no_pop", 64'(fifo_count), 64'd6);
        read_check("retry", 8'h86, 24'h000003);
        for (int k = 4; k <= 8; k++) begin
            read_check("drain", 8'h80 | 8'(9 - k), CH'(k));
        end
        check_eq("drain_count", 64'(fifo_count), 64'd0);
        check_eq("drain_led", 64'(trigger_led), 64'd0);
        spi_read(F);
        check_eq("empty_frame", 64'(rd_frame), 64'd0);
        check_eq("empty_no_pop", 64'(fifo_count), 64'd0);

        // reset in the middle of a window
        pulse(24'h000100);
        cyc(3);
        check_eq("midwin_trigger", 64'(trigger), 64'd1);
        rst_n = 1'b0;
        cyc(1);
        check_eq("midwin_rst_trigger", 64'(trigger), 64'd0);
        rst_n = 1'b1;
        cyc(15);
        check_eq("midwin_rst_count", 64'(fifo_count), 64'd0);

`ifdef HIT_TIMESTAMP_EN
        // events 20 cycles apart: 4-bit timestamps differ by 20 mod 16
        pulse(24'h000001);
        cyc(19);
        pulse(24'h000002);
        cyc(12);
        check_eq("ts_count", 64'(fifo_count), 64'd2);
        read_check("ts_ev1", 8'h82, 24'h000001);
        ts_a = rd_frame[TSW-1:0];
        read_check("ts_ev2", 8'h81, 24'h000002);
        ts_b = rd_frame[TSW-1:0];
        ts_d = ts_b - ts_a;
        check_eq("ts_delta", 64'(ts_d), 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hit_event_fifo.md
# hit_event_fifo

Parametrised successor to the scintillator hit latch. Captures CHANNELS asynchronous hit inputs into a coincidence window and commits each window as one event into a DEPTH-entry FIFO, optionally with a timestamp. An STM32 drains the FIFO over a mode-0 SPI slave interface. Sits between the discriminator outputs and the MCU, on the single fast fabric clock.

## Interface
- CHANNELS, 24, number of hit inputs (1..64)
- DEPTH, 8, FIFO entries; power of two, 2..64
- WINDOW, 64, coincidence window length in sys_clk cycles (1..65535)
- TS_WIDTH, 16, timestamp width (used only with HIT_TIMESTAMP_EN)
- sys_clk  in  1  fabric clock; all logic on its rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- S  in  CHANNELS  asynchronous hit inputs, active-high
- spi_cs  in  1  SPI chip select, active-low, asynchronous
- spi_clk  in  1  SPI clock, CPOL=0 CPHA=0, asynchronous
- spi_miso  out  1  SPI data out, MSB first
- trigger  out  1  high while a coincidence window is open
- trigger_led  out  1  high while FIFO non-empty
- fifo_count  out  $clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky: an event was dropped on full FIFO

## Operation
- S, spi_clk, spi_cs each pass a two-flop synchronizer (sync1, sync2); all logic uses sync2 and its registered previous value.
- Capture FSM, states IDLE, WINDOW, COMMIT:
  - IDLE: if |sync2: Q <= sync2, ts_cap <= ts, win_cnt <= WINDOW-1, go WINDOW.
  - WINDOW: Q <= Q | sync2; if win_cnt==0 go COMMIT else win_cnt--.
  - COMMIT (one cycle): push {ts_cap, Q} if not full, else drop and set overflow. Then Q <= sync2; if |sync2, ts_cap <= ts, win_cnt <= WINDOW-1, go WINDOW; else Q <= 0, go IDLE. No hit is lost across COMMIT.
- ts: free-running TS_WIDTH counter, wraps at 2^TS_WIDTH-1 -> 0.
- SPI frame, F = 8 + CHANNELS (+ TS_WIDTH) bits: header {valid, overflow, count[5:0]}, then Q MSB first, then timestamp MSB first. count = fifo_count before pop, saturated at 63. valid=0 and payload all-zero when FIFO empty.
- CS falling (synced): load shift register with frame, bit_cnt <= 0, spi_miso <= frame MSB.
- Each synced spi_clk rising: bit_cnt++ (saturating at F). Each synced spi_clk falling while bit_cnt<F: shift left, spi_miso <= next bit; after F bits spi_miso = 0.
- CS rising: if bit_cnt==F and valid, pop head; if header overflow bit was 1, clear overflow (unless a drop occurs the same cycle, which wins). bit_cnt < F: no pop, no clear (retry gives same event). spi_miso <= 0.
- Push and pop in same cycle: both performed, fifo_count unchanged. Pop on empty impossible (valid=0).

## Timing
- Reset values: spi_miso 0, trigger 0, trigger_led 0, fifo_count 0, overflow 0; FSM IDLE, Q 0, ts 0, FIFO pointers 0, synchronizers 0 (synced spi_cs reset value 1).
- Hit on S at edge n: sync2 at n+2; trigger high from n+3 for WINDOW+1 cycles (WINDOW states plus COMMIT); fifo_count increments at n+WINDOW+4.
- Pulses shorter than one sys_clk period may be missed; minimum hit width one period.
- spi_clk and spi_cs: each level held >= 4 sys_clk cycles; MISO valid <= 4 sys_clk after the spi_clk falling edge or CS falling edge.
- Reset mid-window or mid-frame: everything returns to reset values next edge; partial frame discarded, no pop.

## Configuration
- HIT_TIMESTAMP_EN defined: ts counter and per-entry TS_WIDTH field exist, F = 8+CHANNELS+TS_WIDTH.
- Undefined: no counter, no timestamp storage, F = 8+CHANNELS; all other behaviour identical.

## Test plan
- Single hit S=0x000001 for 3 cycles, WINDOW=4 -> trigger high 5 cycles, fifo_count 0->1, SPI read returns header 0x81, Q 0x000001.
- Hits 0x000010 at t and 0x800000 at t+2 inside window -> one event, Q=0x800010, fifo_count=1.
- Hit arriving exactly in COMMIT cycle -> two events, second Q equals that hit, trigger stays high continuously.
- Fill DEPTH=8 then 9th event -> fifo_count 8, overflow 1; full read returns header 0xC8, overflow clears after CS rise, count 7.
- CS raised after 10 of F bits -> no pop; next full read returns the same event; read on empty FIFO returns all-zero frame.
- HIT_TIMESTAMP_EN, TS_WIDTH=4: events 20 cycles apart -> timestamps differ by 20 mod 16 = 4.
